// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM states and flag layout for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_MOV   = 5'd0;
  localparam logic [OPW-1:0] OP_ADD   = 5'd1;
  localparam logic [OPW-1:0] OP_ADC   = 5'd2;
  localparam logic [OPW-1:0] OP_SUB   = 5'd3;
  localparam logic [OPW-1:0] OP_SBB   = 5'd4;
  localparam logic [OPW-1:0] OP_AND   = 5'd5;
  localparam logic [OPW-1:0] OP_OR    = 5'd6;
  localparam logic [OPW-1:0] OP_XOR   = 5'd7;
  localparam logic [OPW-1:0] OP_MUL   = 5'd8;
  localparam logic [OPW-1:0] OP_MULH  = 5'd9;
  localparam logic [OPW-1:0] OP_UMULH = 5'd10;
  localparam logic [OPW-1:0] OP_CMP   = 5'd12;
  localparam logic [OPW-1:0] OP_TEST  = 5'd13;
  localparam logic [OPW-1:0] OP_DIVU  = 5'd16;
  localparam logic [OPW-1:0] OP_DIVS  = 5'd17;
  localparam logic [OPW-1:0] OP_REMU  = 5'd18;
  localparam logic [OPW-1:0] OP_REMS  = 5'd19;
  localparam logic [OPW-1:0] OP_LSL   = 5'd20;
  localparam logic [OPW-1:0] OP_LSR   = 5'd21;
  localparam logic [OPW-1:0] OP_ASR   = 5'd22;
  localparam logic [OPW-1:0] OP_ROL   = 5'd23;
  localparam logic [OPW-1:0] OP_ROR   = 5'd24;
  localparam logic [OPW-1:0] OP_CLC   = 5'd25;
  localparam logic [OPW-1:0] OP_STC   = 5'd26;
  localparam logic [OPW-1:0] OP_SAVEF = 5'd29;
  localparam logic [OPW-1:0] OP_RESTF = 5'd30;

  // Bit positions of each flag in the SAVEF/RESTF word.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} aluState_t;

  // Packed so that the struct itself is the SAVEF word {V,S,C,Z}.
  typedef struct packed {
    logic v;
    logic s;
    logic c;
    logic z;
  } aluFlags_t;

  function automatic logic isDivOp(input logic [OPW-1:0] op);
    return (op == OP_DIVU) || (op == OP_DIVS) || (op == OP_REMU) || (op == OP_REMS);
  endfunction

endpackage

// File: rtl/alu_mc_div.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle.
module alu_mc_div #(
  parameter int unsigned BITS = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  input  logic            signedMode,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            dz,
  output logic            ovf,
  output logic            done
);

  localparam int unsigned CW = $clog2(BITS);
  localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS-1){1'b0}}};

  logic [CW-1:0]   cnt;
  logic            busy;
  logic [BITS-1:0] divM;
  logic [BITS-1:0] magA;
  logic [BITS-1:0] magB;
  logic            dzC;
  logic            ovfC;
  logic [BITS:0]   trial;

  // Operand magnitudes, special-case detection and the trial subtraction.
  always_comb begin
    magA  = (signedMode && dividend[BITS-1]) ? -dividend : dividend;
    magB  = (signedMode && divisor[BITS-1]) ? -divisor : divisor;
    dzC   = (divisor == '0);
    ovfC  = signedMode && (dividend == MIN_VAL) && (divisor == '1);
    trial = {remainder, quotient[BITS-1]} - {1'b0, divM};
  end

  // Quotient shifts in from the left end of the dividend; done marks the final iteration.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      busy      <= 1'b0;
      divM      <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= busy && (cnt == CW'(1));
      if (start) begin
        dz   <= dzC;
        ovf  <= ovfC;
        divM <= magB;
        cnt  <= CW'(BITS - 1);
        if (dzC) begin
          quotient  <= '1;
          remainder <= dividend;
          busy      <= 1'b0;
        end else if (ovfC) begin
          quotient  <= MIN_VAL;
          remainder <= '0;
          busy      <= 1'b0;
        end else begin
          quotient  <= magA;
          remainder <= '0;
          busy      <= 1'b1;
        end
      end else if (busy) begin
        if (!trial[BITS]) begin
          remainder <= trial[BITS-1:0];
          quotient  <= {quotient[BITS-2:0], 1'b1};
        end else begin
          remainder <= {remainder[BITS-2:0], quotient[BITS-1]};
          quotient  <= {quotient[BITS-2:0], 1'b0};
        end
        if (cnt == '0) begin
          busy <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle datapath, iterative divider, FSM and held flags.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned BITS = 16,
  parameter int unsigned SHW  = $clog2(BITS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [OPW-1:0]  aluOp,
  input  logic            execute,
  output logic            ready,
  output logic            out_valid,
  output logic [BITS-1:0] aluOut,
  output logic            C,
  output logic            Z,
  output logic            S,
  output logic            V
);

  localparam int unsigned MSB = BITS - 1;
  localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS-1){1'b0}}};

  aluState_t state, stateNext;
  logic      readyNext, outValidNext, accept, startDiv;

  aluFlags_t flagsQ, pendFl, scFl, divFl;
  logic [BITS-1:0] pendRes, scRes, divRes, fixQ, fixR;
  logic            negQ, negR, remSel, divSigned, isSpec, zsRes;

  logic [BITS-1:0]   divQ, divR;
  logic              divDz, divOvf, divDone;
  logic [SHW-1:0]    shN;
  logic [BITS:0]     addSum, subDiff, lslExt, lsrExt, asrExt;
  logic [BITS-1:0]   rolRes, rorRes, mulsHi;
  logic [2*BITS-1:0] prod;

  assign C   = flagsQ.c;
  assign Z   = flagsQ.z;
  assign S   = flagsQ.s;
  assign V   = flagsQ.v;
  assign shN = B[SHW-1:0];

  alu_mc_div #(.BITS(BITS)) uDiv (
    .CLK        (CLK),
    .RST        (RST),
    .start      (startDiv),
    .dividend   (A),
    .divisor    (B),
    .signedMode (divSigned),
    .quotient   (divQ),
    .remainder  (divR),
    .dz         (divDz),
    .ovf        (divOvf),
    .done       (divDone)
  );

  // Divide mode decode and the cases that bypass the iteration.
  always_comb begin
    divSigned = (aluOp == OP_DIVS) || (aluOp == OP_REMS);
    isSpec    = (B == '0) || (divSigned && (A == MIN_VAL) && (B == '1));
  end

  // Single-cycle datapath; signed high product derived from the unsigned one.
  always_comb begin
    prod    = {{BITS{1'b0}}, A} * {{BITS{1'b0}}, B};
    mulsHi  = prod[2*BITS-1:BITS] - (A[MSB] ? B : '0) - (B[MSB] ? A : '0);
    addSum  = {1'b0, A} + {1'b0, B} + (BITS+1)'((aluOp == OP_ADC) && flagsQ.c);
    subDiff = {1'b0, A} - {1'b0, B} - (BITS+1)'((aluOp == OP_SBB) && flagsQ.c);
    lslExt  = {1'b0, A} << shN;
    lsrExt  = {A, 1'b0} >> shN;
    asrExt  = $signed({A, 1'b0}) >>> shN;
    rolRes  = (A << shN) | (A >> (BITS - 32'(shN)));
    rorRes  = (A >> shN) | (A << (BITS - 32'(shN)));
    scRes   = '0;
    scFl    = flagsQ;
    zsRes   = 1'b0;
    case (aluOp)
      OP_MOV: scRes = B;
      OP_ADD, OP_ADC: begin
        scRes  = addSum[MSB:0];
        scFl.c = addSum[BITS];
        scFl.v = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ addSum[MSB]);
        zsRes  = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        scFl.c = subDiff[BITS];
        scFl.v = (A[MSB] ^ B[MSB]) & (A[MSB] ^ subDiff[MSB]);
        if (aluOp == OP_CMP) begin
          scRes  = A;
          scFl.z = (subDiff[MSB:0] == '0);
          scFl.s = subDiff[MSB];
        end else begin
          scRes = subDiff[MSB:0];
          zsRes = 1'b1;
        end
      end
      OP_AND, OP_OR, OP_XOR, OP_MUL, OP_MULH, OP_UMULH: begin
        case (aluOp)
          OP_AND:  scRes = A & B;
          OP_OR:   scRes = A | B;
          OP_XOR:  scRes = A ^ B;
          OP_MUL:  scRes = prod[MSB:0];
          OP_MULH: scRes = mulsHi;
          default: scRes = prod[2*BITS-1:BITS];
        endcase
        scFl.c = 1'b0;
        zsRes  = 1'b1;
      end
      OP_TEST: begin
        scRes  = A;
        scFl.z = ((A & B) == '0);
      end
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
        zsRes = 1'b1;
        if (shN == '0) begin
          scRes = A;
        end else begin
          case (aluOp)
            OP_LSL: begin scRes = lslExt[MSB:0];  scFl.c = lslExt[BITS]; end
            OP_LSR: begin scRes = lsrExt[BITS:1]; scFl.c = lsrExt[0];    end
            OP_ASR: begin scRes = asrExt[BITS:1]; scFl.c = asrExt[0];    end
            OP_ROL: scRes = rolRes;
            default: scRes = rorRes;
          endcase
        end
      end
      OP_CLC:   scFl.c = 1'b0;
      OP_STC:   scFl.c = 1'b1;
      OP_SAVEF: scRes = {{(BITS-4){1'b0}}, flagsQ};
      OP_RESTF: begin
        scFl.z = B[FLAG_Z];
        scFl.c = B[FLAG_C];
        scFl.s = B[FLAG_S];
        scFl.v = B[FLAG_V];
      end
      default: ;
    endcase
    if (zsRes) begin
      scFl.z = (scRes == '0);
      scFl.s = scRes[MSB];
    end
  end

  // Sign fixup of the divider result; special cases already hold final values.
  always_comb begin
    fixQ    = (negQ && !(divDz || divOvf)) ? -divQ : divQ;
    fixR    = (negR && !(divDz || divOvf)) ? -divR : divR;
    divRes  = remSel ? fixR : fixQ;
    divFl.v = divDz || divOvf;
    divFl.s = divRes[MSB];
    divFl.c = 1'b0;
    divFl.z = (divRes == '0);
  end

  // Next-state, handshake and divider start decode.
  always_comb begin
    stateNext    = state;
    readyNext    = ready;
    accept       = 1'b0;
    startDiv     = 1'b0;
    outValidNext = (state == DONE);
    case (state)
      IDLE: begin
        readyNext = 1'b1;
        if (ready && execute) begin
          accept    = 1'b1;
          readyNext = 1'b0;
          if (isDivOp(aluOp)) begin
            startDiv  = 1'b1;
            stateNext = isSpec ? FIX : DIV;
          end else begin
            stateNext = DONE;
          end
        end
      end
      DIV:  if (divDone) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: begin
        stateNext = IDLE;
        readyNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM state and handshake registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ready     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= stateNext;
      ready     <= readyNext;
      out_valid <= outValidNext;
    end
  end

  // Pending result capture and the architectural result/flag update in DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pendRes <= '0;
      pendFl  <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      remSel  <= 1'b0;
      aluOut  <= '0;
      flagsQ  <= '0;
    end else begin
      if (accept && !startDiv) begin
        pendRes <= scRes;
        pendFl  <= scFl;
      end
      if (startDiv) begin
        negQ   <= divSigned && (A[MSB] ^ B[MSB]);
        negR   <= divSigned && A[MSB];
        remSel <= (aluOp == OP_REMU) || (aluOp == OP_REMS);
      end
      if (state == FIX) begin
        pendRes <= divRes;
        pendFl  <= divFl;
      end
      if (state == DONE) begin
        aluOut <= pendRes;
        flagsQ <= pendFl;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at BITS=16 with directed, hand-computed vectors.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        CLK, RST;
  logic [15:0] A, B;
  logic [4:0]  aluOp;
  logic        execute, ready, out_valid;
  logic [15:0] aluOut;
  logic        C, Z, S, V;

  alu_mc #(.BITS(16), .SHW(4)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .aluOp(aluOp), .execute(execute),
    .ready(ready), .out_valid(out_valid), .aluOut(aluOut),
    .C(C), .Z(Z), .S(S), .V(V)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;   // {V,S,C,Z}
    logic        chkRes;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   total = 0;
  int   bad   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge CLK) begin
    if (!RST && out_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 aluOut=%h want no pending result", aluOut);
      end else begin
        monE = sbq.pop_front();
        if (monE.chkRes)
          check($sformatf("result_%0d", monE.tag), 32'(aluOut), 32'(monE.res));
        check($sformatf("flags_VSCZ_%0d", monE.tag), 32'({V, S, C, Z}), 32'(monE.fl));
      end
    end
  end

  task automatic doOp(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] er, input logic [3:0] ef, input logic cr,
                      input int lat, input int tag, input logic disturb);
    int   cyc;
    logic rdyLow;
    exp_t e;
    cyc = 0;
    @(negedge CLK);
    while (!ready && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check($sformatf("ready_before_%0d", tag), 32'(ready), 32'd1);
    A = a; B = b; aluOp = op; execute = 1'b1;
    e.res = er; e.fl = ef; e.chkRes = cr; e.tag = tag;
    sbq.push_back(e);
    @(posedge CLK); #1;
    execute = 1'b0;
    cyc = 0;
    rdyLow = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (ready) rdyLow = 1'b0;
      @(posedge CLK); #1;
      cyc++;
      if (disturb && cyc == 3) begin
        A = 16'h5555; B = 16'h0003; aluOp = OP_MOV; execute = 1'b1;
      end
      if (disturb && cyc == 5) execute = 1'b0;
    end
    check($sformatf("latency_%0d", tag), 32'(cyc), 32'(lat));
    check($sformatf("ready_low_busy_%0d", tag), 32'({rdyLow, ready}), 32'b10);
    @(posedge CLK); #1;
    check($sformatf("ready_back_pulse_end_%0d", tag), 32'({ready, out_valid}), 32'b10);
  endtask

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int seen;
    RST = 1'b1; execute = 1'b0; A = '0; B = '0; aluOp = OP_MOV;
    repeat (2) @(posedge CLK);
    #1 check("reset_state", 32'({ready, out_valid, aluOut, V, S, C, Z}), 32'({1'b1, 1'b0, 16'h0, 4'h0}));
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    check("post_reset_idle", 32'({ready, out_valid, aluOut, V, S, C, Z}), 32'({1'b1, 1'b0, 16'h0, 4'h0}));

    //   op        A         B         result    VSCZ     chk  lat tag disturb
    doOp(OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 1'b1, 1,  1, 1'b0);
    doOp(OP_SUB,   16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1'b1, 1,  2, 1'b0);
    doOp(OP_SBB,   16'h0005, 16'h0001, 16'h0003, 4'b0000, 1'b1, 1,  3, 1'b0);
    doOp(OP_DIVS,  16'hFFF9, 16'h0002, 16'hFFFD, 4'b0100, 1'b1, 18, 4, 1'b1);
    doOp(OP_REMS,  16'hFFF9, 16'h0002, 16'hFFFF, 4'b0100, 1'b1, 18, 5, 1'b0);
    doOp(OP_DIVU,  16'h1234, 16'h0000, 16'hFFFF, 4'b1100, 1'b1, 2,  6, 1'b0);
    doOp(OP_DIVS,  16'h8000, 16'hFFFF, 16'h8000, 4'b1100, 1'b1, 2,  7, 1'b0);
    doOp(OP_DIVU,  16'h0064, 16'h0007, 16'h000E, 4'b0000, 1'b1, 18, 8, 1'b1);
    doOp(OP_REMU,  16'h0064, 16'h0007, 16'h0002, 4'b0000, 1'b1, 18, 9, 1'b0);
    doOp(OP_ASR,   16'h8001, 16'h0001, 16'hC000, 4'b0110, 1'b1, 1, 10, 1'b0);
    doOp(OP_LSL,   16'h00F0, 16'h0010, 16'h00F0, 4'b0010, 1'b1, 1, 11, 1'b0);
    doOp(OP_ROR,   16'h0001, 16'h0004, 16'h1000, 4'b0010, 1'b1, 1, 12, 1'b0);
    doOp(OP_LSR,   16'h0001, 16'h0001, 16'h0000, 4'b0011, 1'b1, 1, 13, 1'b0);
    doOp(OP_CMP,   16'h0005, 16'h0005, 16'h0005, 4'b0001, 1'b1, 1, 14, 1'b0);
    doOp(OP_XOR,   16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000, 1'b1, 1, 15, 1'b0);
    doOp(OP_MULH,  16'hFFFF, 16'h0002, 16'hFFFF, 4'b0100, 1'b1, 1, 16, 1'b0);

    // Reset five cycles into a divide: immediate abort, no result.
    @(negedge CLK);
    A = 16'h00FF; B = 16'h0003; aluOp = OP_DIVU; execute = 1'b1;
    @(posedge CLK); #1;
    execute = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    #1 check("reset_abort", 32'({ready, out_valid, aluOut, V, S, C, Z}), 32'({1'b1, 1'b0, 16'h0, 4'h0}));
    @(negedge CLK) RST = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    check("no_out_valid_after_abort", 32'(seen), 32'd0);

    doOp(OP_RESTF, 16'h0000, 16'h000A, 16'h0000, 4'b1010, 1'b0, 1, 17, 1'b0);
    doOp(OP_SAVEF, 16'h0000, 16'h0000, 16'h000A, 4'b1010, 1'b1, 1, 18, 1'b0);
    doOp(OP_ADC,   16'h0001, 16'h0001, 16'h0003, 4'b0000, 1'b1, 1, 19, 1'b0);
    doOp(OP_UMULH, 16'hFFFF, 16'h0002, 16'h0001, 4'b0000, 1'b1, 1, 20, 1'b0);
    doOp(OP_DIVS,  16'h0007, 16'hFFFE, 16'hFFFD, 4'b0100, 1'b1, 18, 21, 1'b0);
    doOp(OP_REMS,  16'h0007, 16'hFFFE, 16'h0001, 4'b0000, 1'b1, 18, 22, 1'b0);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the successor to the single-cycle 16-bit ALU in the CPU execute stage. It adds a generic datapath width, variable-count barrel shifts, and an iterative signed/unsigned divider with a ready/valid handshake. Flags are held internally, as before. It sits between register-file read and writeback, and the pipeline stalls while `ready` is low.

## Interface
- `BITS`, 16: datapath width, even, ≥8.
- `SHW`, `$clog2(BITS)`: shift-count width.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `A` in BITS: operand A, also the shift source.
- `B` in BITS: operand B, also the shift count (`B[SHW-1:0]`).
- `aluOp` in 5: operation code from `alu_mc_pkg`.
- `execute` in 1: request; accepted only when `ready`=1.
- `ready` out 1: idle, can accept a request.
- `out_valid` out 1: one-cycle pulse, `aluOut` and flags updated.
- `aluOut` out BITS: registered result.
- `C`, `Z`, `S`, `V` out 1 each: carry/borrow, zero, sign, signed overflow.

## Operation
- Ops:
  - MOV=0 (B), ADD=1, ADC=2, SUB=3, SBB=4, AND=5, OR=6, XOR=7.
  - MUL=8 (low half), MULH=9 (signed high), UMULH=10 (unsigned high).
  - CMP=12, TEST=13, DIVU=16, DIVS=17, REMU=18, REMS=19.
  - LSL=20, LSR=21, ASR=22, ROL=23, ROR=24, CLC=25, STC=26.
  - SAVEF=29 (`{0…, V,S,C,Z}`), RESTF=30 (`Z=B[0]`, `C=B[1]`, `S=B[2]`, `V=B[3]`).
  - Other codes: NOP, `aluOut`=0, flags kept.
- Arithmetic at BITS+1 width. C = bit BITS (borrow for SUB/SBB/CMP).
- V for ADD/ADC: `~(A^B)&(A^R)` on the MSB. For SUB/SBB/CMP: `(A^B)&(A^R)`. V uses the actual ADC/SBB result.
- CMP: flags as SUB, `aluOut`=A. TEST: Z only from A&B, `aluOut`=A.
- Logic ops and MUL*: Z and S from the result, C=0, V kept.
- Shifts, n=`B[SHW-1:0]`:
  - n=0: `aluOut`=A, C kept.
  - Else C = last bit shifted out for LSL/LSR/ASR. ROL/ROR keep C.
  - Z and S from the result.
- Divide:
  - Restoring, one quotient bit per cycle on magnitudes. Signs fixed up at the end: quotient negated if the operand signs differ, remainder takes the sign of A.
  - B=0: quotient all-ones, remainder=A, V=1.
  - DIVS/REMS with A=MIN, B=−1: quotient=MIN, remainder=0, V=1.
  - Otherwise V=0. C=0. Z and S from the result.
- Flags and `aluOut` change only in the `out_valid` cycle.

## Timing
- Reset values: `aluOut`=0, C=Z=S=V=0, `out_valid`=0, `ready`=1, FSM=IDLE.
- FSM states:
  - IDLE: `ready`=1. On `execute`, go to DONE (single-cycle op) or to DIV (DIVU/DIVS/REMU/REMS), latching |A|, |B| and signs.
  - DIV: runs BITS iterations on a counter from BITS−1 down to 0. At counter 0, go to FIX. B=0 and the MIN/−1 case skip straight to FIX.
  - FIX: sign fixup, then go to DONE.
  - DONE: registers `aluOut` and flags, drives `out_valid`=1 and `ready`=0, then returns to IDLE.
- Single-cycle op: accept at edge k, `out_valid` at k+1, `ready` back high at k+2.
- Divide: accept at k, `out_valid` at k+BITS+2 (k+2 for special cases).
- `execute` while `ready`=0 is ignored, not queued.
- Operands are sampled only at acceptance. Later changes to A and B do not affect an in-flight divide.
- `RST` mid-divide aborts immediately to reset values. No `out_valid` is produced.

## Structure
- `alu_mc_pkg`: opcode localparams, FSM state enum (IDLE, DIV, FIX, DONE), flag-bit index constants for SAVEF/RESTF.
- Sub-module `alu_mc_div`: iterative divider.
  - Inputs: `start`, dividend, divisor, signed mode.
  - Outputs: quotient, remainder, `dz`, `ovf`, `done`.
  - Shares CLK/RST.
- The top level holds the op decode, single-cycle datapath, FSM and flag registers.

## Test plan (BITS=16)
- ADD A=0x7FFF, B=0x0001 → `aluOut`=0x8000, V=1, S=1, C=0, Z=0, `out_valid` one cycle after accept.
- SUB A=0x0000, B=0x0001 → 0xFFFF, C=1. Then SBB A=0x0005, B=0x0001 → 0x0003.
- DIVS A=0xFFF9 (−7), B=0x0002 → 0xFFFD (−3), `out_valid` at k+18. REMS with the same operands → 0xFFFF. `ready`=0 throughout, and an `execute` pulse mid-divide is ignored.
- DIVU B=0 → 0xFFFF, V=1, latency 2. DIVS 0x8000 / 0xFFFF → 0x8000, V=1.
- ASR A=0x8001, n=1 → 0xC000, C=1. LSL n=0 → A unchanged, C unchanged. ROR A=0x0001, n=4 → 0x1000.
- Assert `RST` at DIV iteration 5 → `ready`=1, all outputs 0, no `out_valid`. Then SAVEF after RESTF B=0x000A → 0x000A.
